// File: rtl/game_sequencer.sv
// Game-flow controller: sequences IDLE/PLAY/HIT/OVER, gates object motion, issues respawn
// and bottle relocation pulses, and tracks lives, score and difficulty level.
module game_sequencer #(
    parameter int LIVES_INIT    = 3,
    parameter int SCORE_W       = 8,
    parameter int DEATH_TICKS   = 30,
    parameter int INVULN_TICKS  = 60,
    parameter int SPEEDUP_EVERY = 5,
    parameter int MAX_LEVEL     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               shark_hit,
    input  logic               bottle_hit,
    output logic [1:0]         state,
    output logic               play_en,
    output logic               respawn,
    output logic               bottle_clr,
    output logic               flash,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         level,
    output logic               game_over
);

    localparam int DW = $clog2(DEATH_TICKS + 1);
    localparam int IW = $clog2(INVULN_TICKS + 1);
    localparam int BW = $clog2(SPEEDUP_EVERY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [DW-1:0]      death_q, death_n;
    logic [IW-1:0]      invuln_q, invuln_n;
    logic [BW-1:0]      bcnt_q, bcnt_n;
    logic [1:0]         lives_n;
    logic [SCORE_W-1:0] score_n;
    logic [1:0]         level_n;
    logic               respawn_n, bottle_clr_n, flash_n;
    logic               start_q, bottle_q;
    logic               start_edge, bottle_edge, shark_eff;

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] sat_inc_level(input logic [1:0] v);
        return (v >= 2'(MAX_LEVEL)) ? v : v + 2'd1;
    endfunction

    assign start_edge  = start && !start_q;
    assign bottle_edge = bottle_hit && !bottle_q;
    assign shark_eff   = shark_hit && (invuln_q == '0);
    assign state       = state_q;

    always_comb begin
        state_n      = state_q;
        death_n      = death_q;
        invuln_n     = invuln_q;
        bcnt_n       = bcnt_q;
        lives_n      = lives;
        score_n      = score;
        level_n      = level;
        respawn_n    = 1'b0;
        bottle_clr_n = 1'b0;
        flash_n      = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_n   = PLAY;
                    lives_n   = 2'(LIVES_INIT);
                    score_n   = '0;
                    level_n   = '0;
                    bcnt_n    = '0;
                    invuln_n  = '0;
                    death_n   = '0;
                    respawn_n = 1'b1;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (invuln_q != '0)
                        invuln_n = invuln_q - IW'(1);
                    // A shark collision pre-empts any bottle collected on the same tick
                    if (shark_eff) begin
                        state_n = HIT;
                        lives_n = lives - 2'd1;
                        death_n = DW'(DEATH_TICKS);
                    end else if (bottle_edge) begin
                        score_n      = sat_inc_score(score);
                        bottle_clr_n = 1'b1;
                        if (bcnt_q >= BW'(SPEEDUP_EVERY - 1)) begin
                            bcnt_n  = '0;
                            level_n = sat_inc_level(level);
                        end else begin
                            bcnt_n = bcnt_q + BW'(1);
                        end
                    end
                end
            end
            HIT: begin
                if (tick) begin
                    death_n = death_q - DW'(1);
                    if (death_q <= DW'(1)) begin
                        death_n = '0;
                        if (lives == 2'd0) begin
                            state_n = OVER;
                        end else begin
                            state_n   = PLAY;
                            respawn_n = 1'b1;
                            invuln_n  = IW'(INVULN_TICKS);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == PLAY && invuln_n != '0)
            flash_n = invuln_n[2];
        else
            flash_n = (state_n == HIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            death_q    <= '0;
            invuln_q   <= '0;
            bcnt_q     <= '0;
            lives      <= '0;
            score      <= '0;
            level      <= '0;
            respawn    <= 1'b0;
            bottle_clr <= 1'b0;
            flash      <= 1'b0;
            play_en    <= 1'b0;
            game_over  <= 1'b0;
            start_q    <= 1'b0;
            bottle_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            death_q    <= death_n;
            invuln_q   <= invuln_n;
            bcnt_q     <= bcnt_n;
            lives      <= lives_n;
            score      <= score_n;
            level      <= level_n;
            respawn    <= respawn_n;
            bottle_clr <= bottle_clr_n;
            flash      <= flash_n;
            play_en    <= (state_n == PLAY);
            game_over  <= (state_n == OVER);
            start_q    <= start;
            // Bottle history only advances on frame ticks so edges are seen at frame rate
            if (tick)
                bottle_q <= bottle_hit;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios plus randomized play against a
// frame-level reference model of the game rules.
module tb_game_sequencer;

    localparam int LIVES_INIT    = 3;
    localparam int SCORE_W       = 8;
    localparam int DEATH_TICKS   = 30;
    localparam int INVULN_TICKS  = 60;
    localparam int SPEEDUP_EVERY = 5;
    localparam int MAX_LEVEL     = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick = 1'b0;
    logic               start = 1'b0;
    logic               shark_hit = 1'b0;
    logic               bottle_hit = 1'b0;
    logic [1:0]         state;
    logic               play_en, respawn, bottle_clr, flash, game_over;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [1:0]         level;

    int n_cmp  = 0;
    int n_fail = 0;

    game_sequencer #(
        .LIVES_INIT   (LIVES_INIT),
        .SCORE_W      (SCORE_W),
        .DEATH_TICKS  (DEATH_TICKS),
        .INVULN_TICKS (INVULN_TICKS),
        .SPEEDUP_EVERY(SPEEDUP_EVERY),
        .MAX_LEVEL    (MAX_LEVEL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .shark_hit (shark_hit),
        .bottle_hit(bottle_hit),
        .state     (state),
        .play_en   (play_en),
        .respawn   (respawn),
        .bottle_clr(bottle_clr),
        .flash     (flash),
        .lives     (lives),
        .score     (score),
        .level     (level),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Reference model: game phase (0 idle, 1 play, 2 hit, 3 over) with plain integer bookkeeping
    int m_phase = 0, m_lives = 0, m_score = 0, m_level = 0, m_collected = 0;
    int m_immune = 0, m_dying = 0;
    bit m_respawn = 0, m_bclr = 0, m_start_prev = 0, m_bottle_prev = 0;
    bit s_rise, b_rise;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0; m_lives = 0; m_score = 0; m_level = 0; m_collected = 0;
            m_immune = 0; m_dying = 0; m_respawn = 0; m_bclr = 0;
            m_start_prev = 0; m_bottle_prev = 0;
        end else begin
            s_rise = start && !m_start_prev;
            m_start_prev = start;
            b_rise = tick && bottle_hit && !m_bottle_prev;
            if (tick) m_bottle_prev = bottle_hit;
            m_respawn = 0;
            m_bclr = 0;
            if ((m_phase == 0 || m_phase == 3) && s_rise) begin
                m_phase = 1; m_lives = LIVES_INIT; m_score = 0; m_level = 0;
                m_collected = 0; m_immune = 0; m_respawn = 1;
            end else if (m_phase == 1 && tick) begin
                if (shark_hit && m_immune == 0) begin
                    m_phase = 2; m_lives = m_lives - 1; m_dying = DEATH_TICKS;
                end else if (b_rise) begin
                    m_score = (m_score + 1 > 2**SCORE_W - 1) ? 2**SCORE_W - 1 : m_score + 1;
                    m_bclr = 1;
                    m_collected = m_collected + 1;
                    if (m_collected == SPEEDUP_EVERY) begin
                        m_collected = 0;
                        m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
                    end
                end
                if (m_immune > 0) m_immune = m_immune - 1;
            end else if (m_phase == 2 && tick) begin
                m_dying = m_dying - 1;
                if (m_dying == 0) begin
                    if (m_lives == 0) m_phase = 3;
                    else begin
                        m_phase = 1; m_respawn = 1; m_immune = INVULN_TICKS;
                    end
                end
            end
        end
    end

    function automatic int exp_flash();
        if (m_phase == 2) return 1;
        if (m_phase == 1 && m_immune > 0) return (m_immune / 4) % 2;
        return 0;
    endfunction

    task automatic cyc(input logic t, input logic s, input logic sh, input logic b);
        tick = t; start = s; shark_hit = sh; bottle_hit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (lives !== 2'd0 || score !== '0 || level !== 2'd0) begin
            n_fail++; $display("FAIL reset_counts: lives %0d score %0d level %0d expected all 0", lives, score, level);
        end
        n_cmp++; if ({play_en, respawn, bottle_clr, flash, game_over} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {play_en, respawn, bottle_clr, flash, game_over});
        end
    endtask

    task automatic test_start();
        cyc(0, 0, 0, 0);
        n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_hold: got %0d expected 0", state); end
        cyc(0, 1, 0, 0);
        n_cmp++; if (state !== 2'd1 || lives !== 2'd3) begin
            n_fail++; $display("FAIL start_play: state %0d lives %0d expected 1/3", state, lives);
        end
        n_cmp++; if (respawn !== 1'b1 || play_en !== 1'b1) begin
            n_fail++; $display("FAIL start_respawn: respawn %b play_en %b expected 1/1", respawn, play_en);
        end
        cyc(0, 1, 0, 0);
        n_cmp++; if (respawn !== 1'b0 || state !== 2'd1) begin
            n_fail++; $display("FAIL start_held: respawn %b state %0d expected 0/1", respawn, state);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_bottle();
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1);
            if (bottle_clr) pulses++;
            cyc(0, 0, 0, 1);
            if (bottle_clr) pulses++;
        end
        n_cmp++; if (score !== 8'd1 || pulses != 1) begin
            n_fail++; $display("FAIL bottle_held: score %0d pulses %0d expected 1/1", score, pulses);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 1);
            n_cmp++; if (bottle_clr !== 1'b1) begin n_fail++; $display("FAIL bottle_clr_edge%0d: got %b expected 1", i, bottle_clr); end
            if (i == 2) begin
                n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL level_early: got %0d expected 0", level); end
            end
        end
        cyc(1, 0, 0, 1);
        n_cmp++; if (score !== 8'd5 || level !== 2'd1 || bottle_clr !== 1'b0) begin
            n_fail++; $display("FAIL bottle_level: score %0d level %0d clr %b expected 5/1/0", score, level, bottle_clr);
        end
    endtask

    task automatic test_shark();
        cyc(1, 0, 1, 0);
        n_cmp++; if (state !== 2'd2 || lives !== 2'd2 || play_en !== 1'b0 || flash !== 1'b1) begin
            n_fail++; $display("FAIL shark_hit: state %0d lives %0d play_en %b flash %b expected 2/2/0/1", state, lives, play_en, flash);
        end
        for (int k = 1; k <= DEATH_TICKS; k++) begin
            cyc(0, (k == 5), 1, 0);
            cyc(1, 0, 0, 0);
            if (k < DEATH_TICKS) begin
                if (k == 5 || k == DEATH_TICKS - 1) begin
                    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL hit_wait%0d: state %0d expected 2", k, state); end
                end
            end else begin
                n_cmp++; if (state !== 2'd1 || respawn !== 1'b1 || lives !== 2'd2) begin
                    n_fail++; $display("FAIL hit_respawn: state %0d respawn %b lives %0d expected 1/1/2", state, respawn, lives);
                end
            end
        end
        cyc(0, 0, 0, 0);
        n_cmp++; if (respawn !== 1'b0) begin n_fail++; $display("FAIL respawn_pulse: got %b expected 0", respawn); end
        for (int k = 1; k <= INVULN_TICKS; k++) begin
            cyc(1, 0, 1, 0);
            n_cmp++; if (state !== 2'd1 || flash !== 1'(((INVULN_TICKS - k) >> 2) & 1)) begin
                n_fail++; $display("FAIL invuln%0d: state %0d flash %b expected 1/%0d", k, state, flash, ((INVULN_TICKS - k) >> 2) & 1);
            end
        end
        cyc(1, 0, 1, 0);
        n_cmp++; if (state !== 2'd2 || lives !== 2'd1) begin
            n_fail++; $display("FAIL shark_after_invuln: state %0d lives %0d expected 2/1", state, lives);
        end
        for (int k = 0; k < DEATH_TICKS; k++) cyc(1, 0, 0, 0);
        n_cmp++; if (state !== 2'd1 || lives !== 2'd1) begin
            n_fail++; $display("FAIL second_respawn: state %0d lives %0d expected 1/1", state, lives);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < INVULN_TICKS; k++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 1);
        n_cmp++; if (state !== 2'd2 || score !== 8'd5 || bottle_clr !== 1'b0 || lives !== 2'd0) begin
            n_fail++; $display("FAIL shark_wins: state %0d score %0d clr %b lives %0d expected 2/5/0/0", state, score, bottle_clr, lives);
        end
    endtask

    task automatic test_game_over();
        for (int k = 0; k < DEATH_TICKS; k++) cyc(1, 0, 0, 0);
        n_cmp++; if (state !== 2'd3 || game_over !== 1'b1 || play_en !== 1'b0) begin
            n_fail++; $display("FAIL over_enter: state %0d game_over %b play_en %b expected 3/1/0", state, game_over, play_en);
        end
        for (int k = 0; k < 6; k++) cyc(1, 0, k[0], k[1]);
        n_cmp++; if (score !== 8'd5 || level !== 2'd1 || state !== 2'd3) begin
            n_fail++; $display("FAIL over_frozen: score %0d level %0d state %0d expected 5/1/3", score, level, state);
        end
        cyc(0, 1, 0, 0);
        n_cmp++; if (state !== 2'd1 || lives !== 2'd3 || score !== 8'd0 || respawn !== 1'b1) begin
            n_fail++; $display("FAIL restart: state %0d lives %0d score %0d respawn %b expected 1/3/0/1", state, lives, score, respawn);
        end
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_mid_reset();
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL pre_reset_hit: state %0d expected 2", state); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (state !== 2'd0 || lives !== 2'd0 || score !== '0 || play_en !== 1'b0 || flash !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: state %0d lives %0d score %0d play_en %b flash %b expected 0", state, lives, score, play_en, flash);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
            n_cmp++; if (int'(state) != m_phase) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d expected %0d", i, state, m_phase); end
            n_cmp++; if (int'(lives) != m_lives) begin n_fail++; $display("FAIL rnd_lives@%0d: got %0d expected %0d", i, lives, m_lives); end
            n_cmp++; if (int'(score) != m_score) begin n_fail++; $display("FAIL rnd_score@%0d: got %0d expected %0d", i, score, m_score); end
            n_cmp++; if (int'(level) != m_level) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", i, level, m_level); end
            n_cmp++; if (respawn !== m_respawn) begin n_fail++; $display("FAIL rnd_respawn@%0d: got %b expected %b", i, respawn, m_respawn); end
            n_cmp++; if (bottle_clr !== m_bclr) begin n_fail++; $display("FAIL rnd_bottle_clr@%0d: got %b expected %b", i, bottle_clr, m_bclr); end
            n_cmp++; if (int'(flash) != exp_flash()) begin n_fail++; $display("FAIL rnd_flash@%0d: got %b expected %0d", i, flash, exp_flash()); end
            n_cmp++; if (play_en !== (m_phase == 1)) begin n_fail++; $display("FAIL rnd_play_en@%0d: got %b expected %b", i, play_en, m_phase == 1); end
            n_cmp++; if (game_over !== (m_phase == 3)) begin n_fail++; $display("FAIL rnd_game_over@%0d: got %b expected %b", i, game_over, m_phase == 3); end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_start();
        test_bottle();
        test_shark();
        test_simultaneous();
        test_game_over();
        test_mid_reset();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
